// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Buffer entry layout and in-flight tracker states.
package fetch_pkg;

  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries.
// Clear wins over push/pop; pop on empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output logic [AW:0]  count,
  output fetch_entry_t head
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fetch_entry_t  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);

  always_ff @(posedge CLK) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues memory reads for
// accepted PCs and buffers the returned words in order.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

  fetch_state_t state;
  logic [31:0]  req_pc;
  logic [AW:0]  count;
  logic [AW+1:0] occ;
  fetch_entry_t head;
  fetch_entry_t wdata;
  logic         pend;
  logic         accept;
  logic         clear;
  logic         push;
  logic         pop;

  // A slot is reserved for the in-flight read so a push never overflows.
  assign pend     = (state == PEND);
  assign occ      = {1'b0, count} + {{(AW+1){1'b0}}, pend};
  assign pc_ready = !reset && !flush && (occ < LIMIT);
  assign accept   = pc_valid & pc_ready;
  assign mem_rd   = accept;
  assign mem_addr = pc_in;

  assign clear = reset | flush;
  assign push  = pend & !clear;
  assign pop   = instr_valid & instr_ready & !clear;

  assign wdata.pc    = req_pc;
  assign wdata.instr = mem_rdata;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= IDLE;
      req_pc <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state  <= PEND;
      req_pc <= pc_in;
    end else begin
      state <= IDLE;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .clear (clear),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign instr_valid = (count != '0);
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered fetch entries (power of two, minimum 2).
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 pc_in  input  32  SHALL be the fetch address offered by the program counter.
REQ-005 pc_valid  input  1  SHALL qualify pc_in.
REQ-006 pc_ready  output  1  SHALL indicate the unit accepts pc_in this cycle; drives the PC's increment enable.
REQ-007 mem_rd  output  1  SHALL be the instruction-memory read strobe.
REQ-008 mem_addr  output  32  SHALL be the instruction-memory read address.
REQ-009 mem_rdata  input  32  SHALL be the memory read data, valid exactly one cycle after mem_rd.
REQ-010 flush  input  1  SHALL discard all buffered and in-flight fetches (branch redirect).
REQ-011 instr_out  output  32  SHALL be the head-entry instruction word.
REQ-012 instr_pc  output  32  SHALL be the head-entry fetch address.
REQ-013 instr_valid  output  1  SHALL qualify instr_out/instr_pc.
REQ-014 instr_ready  input  1  SHALL indicate the downstream consumer takes the head entry.

Function
REQ-015 Accept = pc_valid & pc_ready; mem_rd SHALL equal accept and mem_addr SHALL equal pc_in combinationally.
REQ-016 pc_ready SHALL be 1 iff !reset & !flush & (count + pend) < DEPTH; pend = 1 while a request is in flight.
REQ-017 In-flight tracker SHALL be a 2-state FSM: IDLE -> PEND on accept; PEND -> PEND on accept, else PEND -> IDLE; the accepted address is latched into req_pc.
REQ-018 In PEND, {req_pc, mem_rdata} SHALL be pushed to the FIFO tail unless squashed.
REQ-019 Latency: pc accepted in cycle N -> entry visible with instr_valid=1 in cycle N+2.
REQ-020 instr_valid SHALL be (count != 0); instr_out/instr_pc SHALL reflect the head entry; pop = instr_valid & instr_ready.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 FIFO overflow SHALL be impossible by REQ-016 reservation; pop with count=0 SHALL be ignored.
REQ-023 Full throughput: with instr_ready=1 and pc_valid=1, one accept per cycle SHALL be sustained.
REQ-024 flush=1 SHALL, at the clock edge: zero count and pointers, discard any response arriving that cycle, force FSM to IDLE, accept no request.
REQ-025 flush with simultaneous pop or push SHALL take precedence; neither takes effect.
REQ-026 Stalled consumer (instr_ready=0) SHALL hold instr_out/instr_pc stable while instr_valid=1.
REQ-027 Entry order SHALL match accept order; no reordering or duplication.

Reset
REQ-028 During reset: pc_ready=0, mem_rd=0, instr_valid=0, count=0, pointers=0, FSM=IDLE, req_pc=0.
REQ-029 Reset mid-operation SHALL discard in-flight response and all entries, as flush.
REQ-030 First accept possible in the cycle after reset deasserts.

Structure
REQ-031 Package fetch_pkg SHALL hold DEPTH default, fetch_entry_t {pc[31:0], instr[31:0]}, and the FSM state enum {IDLE, PEND}.
REQ-032 Storage SHALL be one sub-module fetch_fifo (push, pop, clear, count, head), instantiated once.

Verification
REQ-033 Reset, then pc_in=0x100 accepted cycle 1, mem_rdata=0xDEADBEEF cycle 2 -> cycle 3 instr_valid=1, instr_pc=0x100, instr_out=0xDEADBEEF.
REQ-034 Stream pc 0,1,2,...,9 with instr_ready=1 -> 10 entries out in order, pc_ready never drops.
REQ-035 instr_ready=0, stream pc 0..7 -> pc_ready drops after 4 accepts (count+pend=4); instructions 0..3 held; release -> 0..3 out then fetch resumes at 4.
REQ-036 Flush in the cycle response for pc 0x20 returns, with 2 entries buffered -> next cycle instr_valid=0, count=0; next accept pc 0x80 -> first output instr_pc=0x80.
REQ-037 Simultaneous push and pop with count=2 -> count stays 2, head advances one entry.
REQ-038 Assert reset while PEND and count=3 -> next cycle instr_valid=0, pc_ready=0; after release, pc_ready=1 and no stale entry appears.
